// File: rtl/spawn_scheduler_pkg.sv
// Shared constants and types for the obstacle spawn scheduler.
// Holds state/kind encodings, slot count, gap and speed limits, and the
// level -> speed mapping used on every difficulty step.
package spawn_scheduler_pkg;
  localparam int SLOTS        = 7;    // obstacle slots (datacount - 1)
  localparam int SLOT_W       = 3;
  localparam int RANDW        = 8;
  localparam int GAP_W        = 8;    // worst gap is 24 + 31 = 55
  localparam logic [GAP_W-1:0] MIN_GAP  = 8'd24;
  localparam logic [GAP_W-1:0] GAP_MASK = 8'h1F;
  localparam int LEVEL_FRAMES = 512;
  localparam int FRAME_W      = 9;
  localparam logic [2:0] SPEED_INIT = 3'd2;
  localparam logic [2:0] SPEED_MAX  = 3'd6;
  localparam logic [3:0] LEVEL_MAX  = 4'd15;
  localparam logic [3:0] KIND_LEVEL = 4'd2; // flying enemies allowed from here

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_OVER   = 2'b11
  } state_t;

  typedef enum logic {
    KIND_GROUND = 1'b0,
    KIND_FLYING = 1'b1
  } kind_t;

  typedef struct packed {
    logic              valid;
    logic [SLOT_W-1:0] slot;
    logic              kind;
  } spawn_req_t;

  // min(SPEED_INIT + lvl, SPEED_MAX), computed wide so it cannot wrap
  function automatic logic [2:0] speed_for(input logic [3:0] lvl);
    logic [4:0] s;
    s = {2'b00, SPEED_INIT} + {1'b0, lvl};
    if (s > {2'b00, SPEED_MAX}) return SPEED_MAX;
    return s[2:0];
  endfunction
endpackage

// File: rtl/spawn_scheduler_picker.sv
// free_slot_picker: combinational lowest-index free-slot encoder.
// Ports: busy (slot occupancy), idx (lowest free slot), any_free.
module free_slot_picker
  import spawn_scheduler_pkg::*;
(
  input  logic [SLOTS-1:0]  busy,
  output logic [SLOT_W-1:0] idx,
  output logic              any_free
);
  // Scan high to low so the last hit (lowest index) wins.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        idx      = SLOT_W'(i);
        any_free = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: frame-rate obstacle sequencer for the shared slot table.
// Decides when an obstacle may spawn, which free slot gets it and its kind,
// and ramps scroll speed with play time.
// Ports: clk3 frame clock; reset async active-low; start/pause levels;
//   collide pulse; random per-frame word; slot_busy occupancy from movers;
//   spawn_valid/slot/kind request held until spawn_ack; speed, level, state.
module spawn_scheduler
  import spawn_scheduler_pkg::*;
(
  input  logic              clk3,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              collide,
  input  logic [RANDW-1:0]  random,
  input  logic [SLOTS-1:0]  slot_busy,
  output logic              spawn_valid,
  output logic [SLOT_W-1:0] spawn_slot,
  output logic              spawn_kind,
  input  logic              spawn_ack,
  output logic [2:0]        speed,
  output logic [3:0]        level,
  output logic [1:0]        state
);
  state_t             st, nxt;
  spawn_req_t         req;
  logic [GAP_W-1:0]   gap_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic [SLOT_W-1:0]  free_idx;
  logic               any_free;
  logic [2**SLOT_W-1:0] busy_pad;

  free_slot_picker u_pick (
    .busy     (slot_busy),
    .idx      (free_idx),
    .any_free (any_free)
  );

  // Unused index positions read as busy so the slot lookup stays in range.
  assign busy_pad = {{(2**SLOT_W-SLOTS){1'b1}}, slot_busy};

  // start low dominates; OVER only leaves via IDLE, which gives the
  // required start 0 -> 1 edge before the next run.
  always_comb begin
    nxt = st;
    if (!start) nxt = ST_IDLE;
    else begin
      case (st)
        ST_IDLE:   nxt = ST_RUN;
        ST_RUN:    if (collide) nxt = ST_OVER; else if (pause)  nxt = ST_PAUSED;
        ST_PAUSED: if (collide) nxt = ST_OVER; else if (!pause) nxt = ST_RUN;
        default:   nxt = ST_OVER;
      endcase
    end
  end

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) st <= ST_IDLE;
    else        st <= nxt;
  end

  // Counters only advance on frames that begin and end in RUN, so the edge
  // that enters PAUSED/OVER freezes everything (a collide also drops an ack).
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      req       <= '0;
      gap_cnt   <= MIN_GAP;
      frame_cnt <= '0;
      level     <= '0;
      speed     <= SPEED_INIT;
    end else if (st == ST_IDLE && nxt == ST_RUN) begin
      req.valid <= 1'b0;
      gap_cnt   <= MIN_GAP;
      frame_cnt <= '0;
      level     <= '0;
      speed     <= SPEED_INIT;
    end else if (nxt == ST_IDLE || nxt == ST_OVER) begin
      req.valid <= 1'b0;
    end else if (st == ST_RUN && nxt == ST_RUN) begin
      if (frame_cnt == FRAME_W'(LEVEL_FRAMES - 1)) begin
        frame_cnt <= '0;
        if (level != LEVEL_MAX) begin
          level <= level + 4'd1;
          speed <= speed_for(level + 4'd1);
        end
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end

      if (req.valid) begin
        if (spawn_ack) begin
          req.valid <= 1'b0;
          gap_cnt   <= MIN_GAP + (random & GAP_MASK);
        end else if (busy_pad[req.slot]) begin
          // target got taken under us: withdraw and re-pick next frame
          req.valid <= 1'b0;
          gap_cnt   <= '0;
        end
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end else if (any_free) begin
        req.valid <= 1'b1;
        req.slot  <= free_idx;
        req.kind  <= (level >= KIND_LEVEL) ? random[RANDW-1] : KIND_GROUND;
      end
    end
  end

  // A pending request survives PAUSED but is hidden from the movers.
  assign spawn_valid = req.valid && (st != ST_PAUSED);
  assign spawn_slot  = req.slot;
  assign spawn_kind  = req.kind;
  assign state       = st;
endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler: a vector table for the basic
// spawn/handshake/slot-pick flow plus hand sequences for level ramp,
// async reset, pause freeze and collide.
module tb_spawn_scheduler;
  logic       clk3 = 1'b0;
  logic       reset;
  logic       start, pause, collide, spawn_ack;
  logic [7:0] random;
  logic [6:0] slot_busy;
  logic       spawn_valid, spawn_kind;
  logic [2:0] spawn_slot, speed;
  logic [3:0] level;
  logic [1:0] state;

  int nvec = 0;
  int nerr = 0;

  spawn_scheduler dut (
    .clk3        (clk3),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .collide     (collide),
    .random      (random),
    .slot_busy   (slot_busy),
    .spawn_valid (spawn_valid),
    .spawn_slot  (spawn_slot),
    .spawn_kind  (spawn_kind),
    .spawn_ack   (spawn_ack),
    .speed       (speed),
    .level       (level),
    .state       (state)
  );

  always #5 clk3 = ~clk3;

  typedef struct {
    logic       start, ack;
    logic [7:0] rnd;
    logic [6:0] busy;
    int         n;
    logic [1:0] st;
    logic       v;
    logic [2:0] slot;
    logic       kind;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk3);
    #1;
  endtask

  vec_t tbl[16];

  initial begin
    logic pv;
    reset = 1'b0; start = 1'b0; pause = 1'b0; collide = 1'b0;
    spawn_ack = 1'b0; random = 8'h00; slot_busy = 7'h00;

    //            start ack rnd    busy   n   st     v     slot  kind
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 7'h00, 1,  2'd1, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 7'h00, 24, 2'd1, 1'b0, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 7'h00, 1,  2'd1, 1'b1, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'hFF, 7'h00, 10, 2'd1, 1'b1, 3'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h07, 7'h00, 1,  2'd1, 1'b0, 3'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 7'h00, 31, 2'd1, 1'b0, 3'd0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 7'h00, 1,  2'd1, 1'b1, 3'd0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 7'h07, 1,  2'd1, 1'b0, 3'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 7'h07, 1,  2'd1, 1'b1, 3'd3, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h00, 7'h07, 1,  2'd1, 1'b0, 3'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 7'h7F, 24, 2'd1, 1'b0, 3'd0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 7'h7F, 5,  2'd1, 1'b0, 3'd0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 7'h5F, 1,  2'd1, 1'b1, 3'd5, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 8'h00, 7'h00, 1,  2'd1, 1'b0, 3'd0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 7'h00, 1,  2'd0, 1'b0, 3'd0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 7'h00, 1,  2'd1, 1'b0, 3'd0, 1'b0};

    // reset state
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_valid", 32'(spawn_valid), 32'd0);
    chk("rst_slot",  32'(spawn_slot), 32'd0);
    chk("rst_kind",  32'(spawn_kind), 32'd0);
    chk("rst_speed", 32'(speed), 32'd2);
    chk("rst_level", 32'(level), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].start; spawn_ack = tbl[i].ack;
      random = tbl[i].rnd; slot_busy = tbl[i].busy;
      tick(tbl[i].n);
      chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("v%0d_valid", i), 32'(spawn_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("v%0d_slot", i), 32'(spawn_slot), 32'(tbl[i].slot));
        chk($sformatf("v%0d_kind", i), 32'(spawn_kind), 32'(tbl[i].kind));
      end
    end
    spawn_ack = 1'b0;

    // level ramp: fresh RUN entered by tbl[15]; k counts RUN edges since entry
    pv = 1'b0;
    for (int k = 1; k <= 512 * 5; k++) begin
      random = 8'($urandom_range(0, 255));
      spawn_ack = pv;
      tick(1);
      if (spawn_valid && !pv)
        chk("ramp_kind", 32'(spawn_kind),
            ((k - 1) / 512 >= 2) ? 32'(random[7]) : 32'd0);
      pv = spawn_valid;
      if (k % 512 == 0) begin
        chk("ramp_level", 32'(level), 32'(k / 512));
        chk("ramp_speed", 32'(speed), (2 + k / 512 > 6) ? 32'd6 : 32'(2 + k / 512));
      end
    end
    spawn_ack = 1'b0;
    random = 8'h00;

    // async reset mid-RUN, no clock edge in between
    #2 reset = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_valid", 32'(spawn_valid), 32'd0);
    chk("arst_slot",  32'(spawn_slot), 32'd0);
    chk("arst_kind",  32'(spawn_kind), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_speed", 32'(speed), 32'd2);
    #1 reset = 1'b1;

    // pause mid-gap: gap 24 on entry, 10 frames run -> 14 left
    tick(1);
    chk("p_run", 32'(state), 32'd1);
    tick(10);
    pause = 1'b1;
    tick(1);
    chk("p_state", 32'(state), 32'd2);
    tick(19);
    chk("p_state20", 32'(state), 32'd2);
    chk("p_valid20", 32'(spawn_valid), 32'd0);
    pause = 1'b0;
    tick(1);
    chk("p_resume", 32'(state), 32'd1);
    tick(14);
    chk("p_gap_hold", 32'(spawn_valid), 32'd0);
    tick(1);
    chk("p_gap_done", 32'(spawn_valid), 32'd1);
    // pending request hidden while paused, reappears on resume
    pause = 1'b1;
    tick(1);
    chk("p_gate", 32'(spawn_valid), 32'd0);
    pause = 1'b0;
    tick(1);
    chk("p_ungate", 32'(spawn_valid), 32'd1);
    chk("p_slot", 32'(spawn_slot), 32'd0);

    // collide + ack (+ pause): OVER wins
    collide = 1'b1; spawn_ack = 1'b1; pause = 1'b1;
    tick(1);
    chk("c_state", 32'(state), 32'd3);
    chk("c_valid", 32'(spawn_valid), 32'd0);
    collide = 1'b0; spawn_ack = 1'b0; pause = 1'b0;
    tick(3);
    chk("c_hold", 32'(state), 32'd3);
    start = 1'b0;
    tick(1);
    chk("c_idle", 32'(state), 32'd0);
    start = 1'b1;
    tick(1);
    chk("c_rerun", 32'(state), 32'd1);
    chk("c_level", 32'(level), 32'd0);
    chk("c_speed", 32'(speed), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
